store_commit_ctrl: RTL
======================

// Module: store_commit_ctrl
// PURPOSE
//  In-order store queue controller between the LSU and data memory.
//  - Accepts speculative stores tagged with a ROB entry.
//  - Marks them committed when the ROB retires that tag.
//  - Discards uncommitted stores on branch mispredict.
//  - Drains committed stores to memory one at a time over a req/ack handshake.
// PARAMETERS
//  DEPTH  8  queue entries; power of two, >=2
//  AW     3  log2(DEPTH); pointers are AW+1 bits (wrap bit)
// PORTS
//  clk          in   1   clock
//  reset        in   1   asynchronous, active-high
//  alloc_valid  in   1   new store from LSU this cycle
//  alloc_addr   in   32  store address
//  alloc_data   in   32  store data
//  alloc_width  in   3   funct3 width code (000 B, 001 H, 010 W)
//  alloc_rob    in   6   ROB tag of the store; 6'b000000 is illegal
//  full         out  1   no free entry
//  empty        out  1   no valid entry
//  count        out  AW+1  valid entries
//  commit_valid in   1   ROB retiring a store this cycle
//  commit_rob   in   6   tag being retired
//  commit_err   out  1   sticky: commit tag mismatched the oldest uncommitted entry
//  mis_pred     in   1   flush all uncommitted entries
//  mem_req      out  1   drain request
//  mem_addr     out  32  drain address
//  mem_data     out  32  drain data
//  mem_width    out  3   drain width
//  mem_ack      in   1   memory accepted the drain
// BEHAVIOUR
//  - Circular queue with three pointers: head (drain) <= cmt (commit) <= tail (alloc).
//    - Committed region: [head, cmt). Speculative region: [cmt, tail).
//  - Reset values: all pointers 0, full=0, empty=1, count=0, mem_req=0,
//    commit_err=0. Entry contents are don't-care.
//  - full, empty and count are derived from the registered pointers only.
//    - count = tail - head, modulo 2^(AW+1).
//  - Alloc: if alloc_valid && !full && !mis_pred, write the entry at tail and
//    increment tail. If full, the alloc is dropped; the LSU must stall on full.
//  - Commit: if commit_valid && cmt!=tail && rob[cmt]==commit_rob, cmt increments.
//    - Otherwise commit_err sets, and stays set until reset.
//  - Drain:
//    - mem_req = (head!=cmt), registered.
//    - mem_addr, mem_data and mem_width show entry[head] and hold stable while
//      mem_req=1 and mem_ack=0.
//    - On mem_req && mem_ack, head increments.
//    - mem_req deasserts the next cycle if no committed entry remains.
//    - Throughput: one store per cycle when mem_ack is tied high.
//    - mem_ack while mem_req=0 is ignored.
//  - Mispredict: the same-cycle commit is applied first; then tail <= cmt
//    (post-commit value).
//    - The same-cycle alloc is ignored.
//    - Committed and draining entries are unaffected.
//  - Simultaneous events in one cycle: alloc, commit and drain ack all take
//    effect together.
//    - When full, a same-cycle ack does not admit an alloc.
//  - Pointer wrap: index = ptr[AW-1:0]; full when index bits are equal and
//    wrap bits differ.
//  - Async reset mid-drain abandons the in-flight request; the memory side must
//    also be reset.
// CONFIGURATION
//  - SB_LOAD_FWD_EN defined: adds ports
//    - ld_addr    in   32
//    - fwd_hit    out  1
//    - fwd_data   out  32
//    - fwd_stall  out  1
//    The forwarding path is combinational and scans valid entries [head, tail)
//    from youngest to oldest for addr[31:2]==ld_addr[31:2].
//    - Youngest match is a W store: fwd_hit=1, fwd_data=its data.
//    - Youngest match is a B or H store: fwd_stall=1, fwd_hit=0.
//    - No match: both outputs are 0.
//  - SB_LOAD_FWD_EN undefined: those ports and that logic are absent.
//    - Loads must wait until the queue is empty.
// TESTING
//  - Reset, 3 allocs (rob 1,2,3), commit 1,2, ack held high:
//    - exactly 2 mem_req beats (addr of rob1, then rob2);
//    - count 3->1; empty=0.
//  - Fill 8 entries -> full=1; a 9th alloc is dropped.
//    - Commit all, drain with ack on alternate cycles -> 8 beats in order;
//      payload stable during stalls; empty=1 at the end.
//  - 5 allocs, commit 2, mis_pred together with commit of the 3rd tag:
//    - count=3 next cycle; the 3 committed stores drain;
//    - the same-cycle alloc is absent.
//  - commit_rob=7 while the oldest uncommitted tag is 4:
//    - commit_err=1 and stays set; cmt unchanged.
//  - Run 20 alloc/commit/drain rounds with DEPTH=8 to cross the wrap:
//    - drain order equals alloc order; full and empty are correct at the
//      wrap boundary.
//  - SB_LOAD_FWD_EN: SW 0x100=0xAA, SW 0x100=0xBB, then ld 0x102
//    - fwd_hit=1, fwd_data=0xBB;
//    - after an SB to 0x101, fwd_stall=1.

Source files
------------

// File: rtl/store_commit_ctrl_if.sv
// store_commit_ctrl_if
//   Bundles the LSU allocation port, the ROB commit/flush port, queue status
//   and the memory drain handshake of the store commit controller.
//   master : LSU/ROB/memory side (drives alloc, commit, mis_pred, mem_ack)
//   slave  : the controller (drives status and the drain request/payload)
//   Optional feature: SB_LOAD_FWD_EN adds ld_addr (in to slave) and
//   fwd_hit/fwd_data/fwd_stall (out of slave).
interface store_commit_ctrl_if #(
    parameter int unsigned AW = 3
);
    logic        alloc_valid;
    logic [31:0] alloc_addr;
    logic [31:0] alloc_data;
    logic [2:0]  alloc_width;
    logic [5:0]  alloc_rob;
    logic        full;
    logic        empty;
    logic [AW:0] count;
    logic        commit_valid;
    logic [5:0]  commit_rob;
    logic        commit_err;
    logic        mis_pred;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [2:0]  mem_width;
    logic        mem_ack;
`ifdef SB_LOAD_FWD_EN
    logic [31:0] ld_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        fwd_stall;

    modport master (
        output alloc_valid, alloc_addr, alloc_data, alloc_width, alloc_rob,
        output commit_valid, commit_rob, mis_pred, mem_ack, ld_addr,
        input  full, empty, count, commit_err,
        input  mem_req, mem_addr, mem_data, mem_width,
        input  fwd_hit, fwd_data, fwd_stall
    );

    modport slave (
        input  alloc_valid, alloc_addr, alloc_data, alloc_width, alloc_rob,
        input  commit_valid, commit_rob, mis_pred, mem_ack, ld_addr,
        output full, empty, count, commit_err,
        output mem_req, mem_addr, mem_data, mem_width,
        output fwd_hit, fwd_data, fwd_stall
    );
`else
    modport master (
        output alloc_valid, alloc_addr, alloc_data, alloc_width, alloc_rob,
        output commit_valid, commit_rob, mis_pred, mem_ack,
        input  full, empty, count, commit_err,
        input  mem_req, mem_addr, mem_data, mem_width
    );

    modport slave (
        input  alloc_valid, alloc_addr, alloc_data, alloc_width, alloc_rob,
        input  commit_valid, commit_rob, mis_pred, mem_ack,
        output full, empty, count, commit_err,
        output mem_req, mem_addr, mem_data, mem_width
    );
`endif
endinterface

// File: rtl/store_commit_ctrl.sv
// store_commit_ctrl
//   In-order store queue between the LSU and data memory. Stores enter
//   speculatively at tail, become committed when the ROB retires their tag
//   (cmt advances), and drain one at a time from head over mem_req/mem_ack.
//   A mispredict drops the speculative region [cmt, tail).
// Ports
//   clk   : clock
//   reset : asynchronous, active-high
//   bus   : store_commit_ctrl_if.slave (alloc, commit, status, drain)
// Configuration
//   SB_LOAD_FWD_EN : adds a combinational store-to-load forwarding lookup
//                    (ld_addr -> fwd_hit/fwd_data/fwd_stall). Without it,
//                    loads must wait for the queue to be empty.
module store_commit_ctrl #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input logic                clk,
    input logic                reset,
    store_commit_ctrl_if.slave bus
);
    typedef logic [AW:0] ptr_t;

    localparam logic [2:0] WIDTH_W = 3'b010;

    ptr_t head_q, head_d;
    ptr_t cmt_q,  cmt_d;
    ptr_t tail_q, tail_d;
    logic mem_req_q, mem_req_d;
    logic err_q, err_d;

    // Entry storage has no reset; contents are only read inside [head, tail).
    logic [31:0] addr_mem  [DEPTH];
    logic [31:0] data_mem  [DEPTH];
    logic [2:0]  width_mem [DEPTH];
    logic [5:0]  rob_mem   [DEPTH];

    logic full_w, empty_w;
    ptr_t count_w;
    logic alloc_ok, commit_ok, drain_ok;

    assign full_w  = (tail_q[AW-1:0] == head_q[AW-1:0]) && (tail_q[AW] != head_q[AW]);
    assign empty_w = (tail_q == head_q);
    assign count_w = tail_q - head_q;

    always_comb begin
        alloc_ok  = bus.alloc_valid && !full_w && !bus.mis_pred;
        commit_ok = bus.commit_valid && (cmt_q != tail_q) &&
                    (rob_mem[cmt_q[AW-1:0]] == bus.commit_rob);
        drain_ok  = mem_req_q && bus.mem_ack;

        err_d  = err_q | (bus.commit_valid & ~commit_ok);
        cmt_d  = cmt_q + ptr_t'(commit_ok);
        head_d = head_q + ptr_t'(drain_ok);
        // Flush rewinds tail to the post-commit cmt, so a same-cycle commit survives.
        tail_d = bus.mis_pred ? cmt_d : (tail_q + ptr_t'(alloc_ok));
        // Registered copy of (head != cmt) for the next cycle.
        mem_req_d = (head_d != cmt_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q    <= '0;
            cmt_q     <= '0;
            tail_q    <= '0;
            mem_req_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            head_q    <= head_d;
            cmt_q     <= cmt_d;
            tail_q    <= tail_d;
            mem_req_q <= mem_req_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_ok) begin
            addr_mem[tail_q[AW-1:0]]  <= bus.alloc_addr;
            data_mem[tail_q[AW-1:0]]  <= bus.alloc_data;
            width_mem[tail_q[AW-1:0]] <= bus.alloc_width;
            rob_mem[tail_q[AW-1:0]]   <= bus.alloc_rob;
        end
    end

    assign bus.full       = full_w;
    assign bus.empty      = empty_w;
    assign bus.count      = count_w;
    assign bus.commit_err = err_q;
    assign bus.mem_req    = mem_req_q;
    // Entry at head is never rewritten while it is valid, so the payload
    // holds steady across ack stalls.
    assign bus.mem_addr   = addr_mem[head_q[AW-1:0]];
    assign bus.mem_data   = data_mem[head_q[AW-1:0]];
    assign bus.mem_width  = width_mem[head_q[AW-1:0]];

`ifdef SB_LOAD_FWD_EN
    ptr_t        scan_ptr;
    logic        fwd_hit_w, fwd_stall_w;
    logic [31:0] fwd_data_w;
    logic        unused_ld_lsb;

    assign unused_ld_lsb = ^bus.ld_addr[1:0];

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        scan_ptr    = head_q;
        fwd_hit_w   = 1'b0;
        fwd_stall_w = 1'b0;
        fwd_data_w  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            scan_ptr = head_q + ptr_t'(i);
            if ((ptr_t'(i) < count_w) &&
                (addr_mem[scan_ptr[AW-1:0]][31:2] == bus.ld_addr[31:2])) begin
                if (width_mem[scan_ptr[AW-1:0]] == WIDTH_W) begin
                    fwd_hit_w   = 1'b1;
                    fwd_stall_w = 1'b0;
                    fwd_data_w  = data_mem[scan_ptr[AW-1:0]];
                end else begin
                    fwd_hit_w   = 1'b0;
                    fwd_stall_w = 1'b1;
                    fwd_data_w  = '0;
                end
            end
        end
    end

    assign bus.fwd_hit   = fwd_hit_w;
    assign bus.fwd_stall = fwd_stall_w;
    assign bus.fwd_data  = fwd_data_w;
`endif
endmodule
